// File: rtl/adc_uart_framer.sv
// Captures two-channel 14-bit ADC conversions into a small FIFO and sends each
// sample to the UART as a 6-byte frame: sync, seq/ch0, ch1, checksum.
module adc_uart_framer #(
    parameter int unsigned FIFO_W = 2,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic              end_conv,
    input  logic [13:0]       ch0,
    input  logic [13:0]       ch1,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              busy,
    output logic [FIFO_W:0]   fifo_level,
    output logic [7:0]        overflow_cnt
);

    localparam int unsigned DEPTH   = 1 << FIFO_W;
    localparam int unsigned ENTRY_W = 30;
    localparam logic [FIFO_W:0] FULL_LVL = (FIFO_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t               r_state;
    logic [2:0]           r_sync;
    logic [1:0]           r_seq;
    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [FIFO_W-1:0]    r_wr_ptr;
    logic [FIFO_W-1:0]    r_rd_ptr;
    logic [1:0]           r_fseq;
    logic [13:0]          r_c0;
    logic [13:0]          r_c1;
    logic [2:0]           r_idx;

    logic                 w_cap;
    logic                 w_take;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_entry;
    logic [7:0]           w_b1, w_b2, w_b3, w_b4, w_b5;
    logic [7:0]           w_byte;

    // Rising edge of the synchronised conversion-done level
    assign w_cap  = r_sync[1] & ~r_sync[2];
    assign w_take = w_cap & enable;
    assign w_full = (fifo_level == FULL_LVL);
    assign w_pop  = (r_state == IDLE) && (fifo_level != '0);
    assign w_push = w_take & (~w_full | w_pop);
    assign w_drop = w_take & w_full & ~w_pop;
    assign w_entry = r_mem[r_rd_ptr];

    assign w_b1 = {r_fseq, r_c0[13:8]};
    assign w_b2 = r_c0[7:0];
    assign w_b3 = {2'b00, r_c1[13:8]};
    assign w_b4 = r_c1[7:0];
    assign w_b5 = w_b1 ^ w_b2 ^ w_b3 ^ w_b4;

    always_comb begin
        w_byte = SYNC;
        case (r_idx)
            3'd1:    w_byte = w_b1;
            3'd2:    w_byte = w_b2;
            3'd3:    w_byte = w_b3;
            3'd4:    w_byte = w_b4;
            3'd5:    w_byte = w_b5;
            default: w_byte = SYNC;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], end_conv};
        end
    end

    // Sample storage carries the sequence number assigned at push time
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_seq, ch1, ch0};
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            fifo_level   <= '0;
            r_seq        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_W'(1);
                r_seq    <= r_seq + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_W'(1);
            end
            if (w_push && !w_pop) begin
                fifo_level <= fifo_level + (FIFO_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                fifo_level <= fifo_level - (FIFO_W + 1)'(1);
            end
            if (w_drop && overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    // Frame sequencer: one strobe per byte with a mandatory low cycle after it
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_fseq  <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_idx   <= '0;
            wr_uart <= 1'b0;
            w_data  <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    wr_uart <= 1'b0;
                    if (w_pop) begin
                        r_fseq  <= w_entry[29:28];
                        r_c1    <= w_entry[27:14];
                        r_c0    <= w_entry[13:0];
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_full) begin
                        wr_uart <= 1'b1;
                        w_data  <= w_byte;
                        r_state <= GAP;
                    end else begin
                        wr_uart <= 1'b0;
                    end
                end
                GAP: begin
                    wr_uart <= 1'b0;
                    if (r_idx == 3'd5) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= SEND;
                    end
                end
                default: begin
                    wr_uart <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
// Directed bench for adc_uart_framer: a frame-level byte model feeds an
// expected-byte queue that a per-cycle monitor checks every UART strobe against.
module tb_adc_uart_framer;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        end_conv = 1'b0;
    logic [13:0] ch0 = '0;
    logic [13:0] ch1 = '0;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    adc_uart_framer #(.FIFO_W(2), .SYNC(8'hA5)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .end_conv(end_conv),
        .ch0(ch0), .ch1(ch1), .tx_full(tx_full), .wr_uart(wr_uart),
        .w_data(w_data), .busy(busy), .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt)
    );

    always #5 CLK = ~CLK;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [1:0] m_seq = 2'd0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: build a frame from the field rules and queue the expected bytes
    task automatic model_push(input logic [13:0] c0, input logic [13:0] c1);
        logic [7:0] b [6];
        b[0] = 8'hA5;
        b[1] = {m_seq, c0[13:8]};
        b[2] = c0[7:0];
        b[3] = {2'b00, c1[13:8]};
        b[4] = c1[7:0];
        b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
        m_seq = m_seq + 2'd1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic conv(input logic [13:0] c0, input logic [13:0] c1,
                        input bit acc, input int hi, input int lo);
        ch0 = c0;
        ch1 = c1;
        end_conv = 1'b1;
        if (acc) model_push(c0, c1);
        repeat (hi) tick();
        end_conv = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_idle(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (exp_q.size() == 0) && !busy && (fifo_level == 3'd0);
        end
        chk("idle_reached", int'(done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_seq = 2'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Monitor: every strobe must match the model, never back-to-back, never after tx_full
    initial begin
        logic       prev_wr;
        logic       txf_prev;
        logic [7:0] last_w;
        logic [7:0] e;
        prev_wr = 1'b0;
        txf_prev = 1'b0;
        last_w = 8'h00;
        forever begin
            @(negedge CLK);
            if (reset) begin
                last_w = 8'h00;
                prev_wr = 1'b0;
            end else begin
                if (wr_uart) begin
                    chk("strobe_gap", int'(prev_wr), 0);
                    chk("strobe_during_full", int'(txf_prev), 0);
                    chk("strobe_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("w_data", int'(w_data), int'(e));
                    end
                    got.push_back(w_data);
                    last_w = w_data;
                end else begin
                    chk("w_data_hold", int'(w_data), int'(last_w));
                end
                prev_wr = wr_uart;
            end
            txf_prev = tx_full;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         n;
        logic [7:0] t1 [6];
        logic [7:0] w1 [5];
        logic [1:0] sq [5];
        logic [7:0] v;

        t1 = '{8'hA5, 8'h2A, 8'hBC, 8'h01, 8'h55, 8'hC2};
        w1 = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
        sq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        repeat (2) tick();
        chk("rst_wr_uart", int'(wr_uart), 0);
        chk("rst_w_data", int'(w_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow_cnt), 0);
        reset = 1'b0;
        tick();

        // Single sample with literal bytes
        base = got.size();
        conv(14'h2ABC, 14'h0155, 1'b1, 4, 4);
        chk("busy_mid_frame", int'(busy), 1);
        wait_idle(100);
        chk("t1_count", got.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            v = got[base + i];
            chk("t1_byte", int'(v), int'(t1[i]));
        end

        // Sequence wrap over five zero samples
        do_reset();
        base = got.size();
        for (int i = 0; i < 5; i++) conv(14'h0000, 14'h0000, 1'b1, 4, 4);
        wait_idle(200);
        chk("wrap_count", got.size() - base, 30);
        for (int k = 0; k < 5; k++) begin
            v = got[base + 6*k + 1];
            chk("wrap_byte1", int'(v), int'(w1[k]));
            v = got[base + 6*k + 5];
            chk("wrap_csum", int'(v), int'(w1[k]));
        end

        // Stall after the second byte
        base = got.size();
        ch0 = 14'h1234;
        ch1 = 14'h0ABC;
        model_push(14'h1234, 14'h0ABC);
        end_conv = 1'b1;
        n = 0;
        while (got.size() - base < 2 && n < 60) begin
            tick();
            n++;
            if (n == 4) end_conv = 1'b0;
        end
        chk("stall_reach_byte2", got.size() - base, 2);
        tx_full = 1'b1;
        repeat (20) tick();
        chk("stall_no_strobe", got.size() - base, 2);
        tx_full = 1'b0;
        wait_idle(100);
        chk("stall_count", got.size() - base, 6);
        v = got[base + 2];
        chk("stall_next_byte", int'(v), 32'h34);

        // Overflow with back-pressure held, capture latency checked on the first sample
        do_reset();
        tx_full = 1'b1;
        base = got.size();
        ch0 = 14'h0111;
        ch1 = 14'h3FFF;
        end_conv = 1'b1;
        model_push(14'h0111, 14'h3FFF);
        repeat (2) tick();
        chk("lat_edge2_level", int'(fifo_level), 0);
        tick();
        chk("lat_edge3_level", int'(fifo_level), 1);
        tick();
        chk("lat_pop_level", int'(fifo_level), 0);
        chk("lat_pop_busy", int'(busy), 1);
        end_conv = 1'b0;
        repeat (10) tick();
        for (int i = 1; i < 6; i++)
            conv(14'(i * 32'h0111), 14'(32'h3FFF - i), i < 5, 4, 10);
        chk("ovf_level", int'(fifo_level), 4);
        chk("ovf_count", int'(overflow_cnt), 1);
        chk("ovf_no_strobe", got.size() - base, 0);
        tx_full = 1'b0;
        wait_idle(300);
        chk("ovf_frames", got.size() - base, 30);
        for (int k = 0; k < 5; k++) begin
            v = got[base + 6*k + 1];
            chk("ovf_seq", int'(v[7:6]), int'(sq[k]));
        end

        // Enable low ignores conversions
        base = got.size();
        enable = 1'b0;
        conv(14'h0AAA, 14'h0555, 1'b0, 4, 4);
        conv(14'h0BBB, 14'h0666, 1'b0, 4, 4);
        repeat (10) tick();
        chk("dis_no_strobe", got.size() - base, 0);
        chk("dis_overflow", int'(overflow_cnt), 1);
        chk("dis_level", int'(fifo_level), 0);
        enable = 1'b1;

        // Reset mid-frame while the third byte is on the bus
        base = got.size();
        conv(14'h0AAA, 14'h1555, 1'b1, 4, 0);
        n = 0;
        while (!(got.size() - base == 2 && wr_uart) && n < 50) begin
            tick();
            n++;
        end
        chk("rst_reach_byte3", int'(wr_uart), 1);
        reset = 1'b1;
        #1;
        chk("midrst_wr_uart", int'(wr_uart), 0);
        chk("midrst_w_data", int'(w_data), 0);
        chk("midrst_level", int'(fifo_level), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overflow", int'(overflow_cnt), 0);
        exp_q.delete();
        m_seq = 2'd0;
        ch0 = 14'h3FFF;
        ch1 = 14'h2000;
        end_conv = 1'b1;
        model_push(14'h3FFF, 14'h2000);
        repeat (2) tick();
        base = got.size();
        reset = 1'b0;
        repeat (6) tick();
        end_conv = 1'b0;
        repeat (4) tick();
        wait_idle(100);
        chk("postrst_count", got.size() - base, 6);
        v = got[base + 1];
        chk("postrst_byte1", int'(v), 32'h3F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
